// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity modes, legal parameter ranges.
package uart_pkg;

  // Transmit/receive frame phases
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Parity mode selectors
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  // Legal parameter ranges
  localparam int unsigned DATA_W_MIN       = 5;
  localparam int unsigned DATA_W_MAX       = 9;
  localparam int unsigned STOP_BITS_MIN    = 1;
  localparam int unsigned STOP_BITS_MAX    = 2;
  localparam int unsigned CLKS_PER_BIT_MIN = 2;

  // Parity over a zero-extended data word; zero padding does not change the XOR
  function automatic logic calc_parity(input logic [DATA_W_MAX-1:0] data,
                                       input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on the last count, held at 0 by clr.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned     CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, wrap at the bit boundary, otherwise increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Bit boundary marker
  assign tick_c = !clr && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/ready word intake, framing FSM, registered serial output.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned BIT_W    = $clog2(DATA_W + 1);
  localparam logic        PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  // Elaboration-time parameter legality
  if ((DATA_W < DATA_W_MIN) || (DATA_W > DATA_W_MAX)) begin : g_bad_data_w
    $fatal(1, "uart_tx_ctrl: DATA_W=%0d outside %0d..%0d", DATA_W, DATA_W_MIN, DATA_W_MAX);
  end
  if ((STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX)) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_ctrl: STOP_BITS=%0d outside %0d..%0d", STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX);
  end
  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
    $fatal(1, "uart_tx_ctrl: CLKS_PER_BIT=%0d below %0d", CLKS_PER_BIT, CLKS_PER_BIT_MIN);
  end
  if (PARITY_EN > 1) begin : g_bad_parity_en
    $fatal(1, "uart_tx_ctrl: PARITY_EN=%0d must be 0 or 1", PARITY_EN);
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $fatal(1, "uart_tx_ctrl: PARITY_ODD=%0d must be 0 or 1", PARITY_ODD);
  end

  uart_state_e       state_q;
  uart_state_e       state_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              par_q;
  logic              par_d;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_d;
  logic              tx_q;
  logic              tx_d;
  logic              ready_q;
  logic              ready_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;

  logic              transfer_c;
  logic              tick_c;
  logic              baud_clr_c;
  logic              last_data_bit_c;
  logic              last_stop_bit_c;

  // Handshake and bit-position decodes
  assign transfer_c      = tx_valid && ready_q;
  assign baud_clr_c      = (state_q == IDLE);
  assign last_data_bit_c = (bit_cnt_q == BIT_W'(DATA_W - 1));
  assign last_stop_bit_c = (bit_cnt_q == BIT_W'(STOP_BITS - 1));

  // Bit-period timing; held cleared while idle so a frame starts on a fresh count
  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (baud_clr_c),
    .tick_c (tick_c)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: advance one frame phase per bit boundary
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (transfer_c) state_d = START;
      end
      START: begin
        if (tick_c) state_d = DATA;
      end
      DATA: begin
        if (tick_c && last_data_bit_c) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (tick_c) state_d = STOP;
      end
      STOP: begin
        if (tick_c && last_stop_bit_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: word/parity capture on transfer, shift and bit count per boundary
  always_comb begin
    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    if (transfer_c) begin
      shift_d   = tx_data;
      par_d     = calc_parity(DATA_W_MAX'(tx_data), PAR_MODE);
      bit_cnt_d = '0;
    end else if (tick_c) begin
      case (state_q)
        DATA: begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = last_data_bit_c ? '0 : bit_cnt_q + BIT_W'(1);
        end
        STOP: begin
          bit_cnt_d = last_stop_bit_c ? '0 : bit_cnt_q + BIT_W'(1);
        end
        default: begin
          bit_cnt_d = bit_cnt_q;
        end
      endcase
    end
  end

  // FSM outputs, decoded from the next state so the registers line up with the state
  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        done_d  = (state_q == STOP);
      end
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = shift_d[0];
        busy_d = 1'b1;
      end
      PARITY: begin
        tx_d   = par_d;
        busy_d = 1'b1;
      end
      STOP: begin
        busy_d = 1'b1;
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase
  end

  // Datapath and output registers; reset forces the line high immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl across four parameter sets at CLKS_PER_BIT=4.
module tb_uart_tx_ctrl;

  localparam int unsigned CPB = 4;

  logic       clk;
  logic       rstn;
  logic       valid_s [4];
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [7:0] data_c;
  logic [4:0] data_d;
  logic       tx_s    [4];
  logic       ready_s [4];
  logic       busy_s  [4];
  logic       done_s  [4];

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default frame: 8 data, even parity, 1 stop
  uart_tx_ctrl #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_dflt (
    .clk(clk), .rstn(rstn), .tx_valid(valid_s[0]), .tx_data(data_a),
    .tx_ready(ready_s[0]), .tx(tx_s[0]), .tx_busy(busy_s[0]), .tx_done(done_s[0]));

  // Odd parity
  uart_tx_ctrl #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_odd (
    .clk(clk), .rstn(rstn), .tx_valid(valid_s[1]), .tx_data(data_b),
    .tx_ready(ready_s[1]), .tx(tx_s[1]), .tx_busy(busy_s[1]), .tx_done(done_s[1]));

  // No parity, two stop bits
  uart_tx_ctrl #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) u_np2s (
    .clk(clk), .rstn(rstn), .tx_valid(valid_s[2]), .tx_data(data_c),
    .tx_ready(ready_s[2]), .tx(tx_s[2]), .tx_busy(busy_s[2]), .tx_done(done_s[2]));

  // 5-bit words, even parity
  uart_tx_ctrl #(.DATA_W(5), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_w5 (
    .clk(clk), .rstn(rstn), .tx_valid(valid_s[3]), .tx_data(data_d),
    .tx_ready(ready_s[3]), .tx(tx_s[3]), .tx_busy(busy_s[3]), .tx_done(done_s[3]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive_data(input int idx, input logic [8:0] d);
    case (idx)
      0:       data_a = d[7:0];
      1:       data_b = d[7:0];
      2:       data_c = d[7:0];
      default: data_d = d[4:0];
    endcase
  endtask

  // Send one word from IDLE (called at a negedge) and check every cycle of the frame
  task automatic send_frame(input int idx, input logic [8:0] d, input logic [15:0] frame,
                            input int nbits, input string tag);
    chk($sformatf("%s idle ready", tag), ready_s[idx], 1'b1);
    chk($sformatf("%s idle busy", tag), busy_s[idx], 1'b0);
    valid_s[idx] = 1'b1;
    drive_data(idx, d);
    @(negedge clk);
    valid_s[idx] = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        chk($sformatf("%s tx bit%0d c%0d", tag, k, c), tx_s[idx], frame[k]);
        chk($sformatf("%s busy bit%0d c%0d", tag, k, c), busy_s[idx], 1'b1);
        if (c == 0) begin
          chk($sformatf("%s ready bit%0d", tag, k), ready_s[idx], 1'b0);
          chk($sformatf("%s done bit%0d", tag, k), done_s[idx], 1'b0);
        end
        @(negedge clk);
      end
    end
    chk($sformatf("%s done pulse", tag), done_s[idx], 1'b1);
    chk($sformatf("%s busy end", tag), busy_s[idx], 1'b0);
    chk($sformatf("%s tx end", tag), tx_s[idx], 1'b1);
    chk($sformatf("%s ready end", tag), ready_s[idx], 1'b1);
    @(negedge clk);
    chk($sformatf("%s done clear", tag), done_s[idx], 1'b0);
  endtask

  initial begin
    logic [2:0] b2b_bit0;
    logic [2:0] b2b_bit1;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 4; i++) valid_s[i] = 1'b0;
    data_a = '0;
    data_b = '0;
    data_c = '0;
    data_d = '0;
    b2b_bit0 = 3'b101;  // LSBs of 03,02,01 (index = frame)
    b2b_bit1 = 3'b110;  // bit1 of 03,02,01

    // Reset values while rstn is low
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst tx%0d", i), tx_s[i], 1'b1);
      chk($sformatf("rst ready%0d", i), ready_s[i], 1'b0);
      chk($sformatf("rst busy%0d", i), busy_s[i], 1'b0);
      chk($sformatf("rst done%0d", i), done_s[i], 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst held ready", ready_s[0], 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("post rst ready%0d", i), ready_s[i], 1'b1);

    // Frames for each parameter set: {stop.., parity, data LSB-first, start}
    send_frame(0, 9'h0A5, 16'b1_0_1010_0101_0, 11, "dflt_a5");
    send_frame(1, 9'h000, 16'b1_1_0000_0000_0, 11, "odd_00");
    send_frame(2, 9'h0FF, 16'b1_1_1111_1111_0, 11, "np2s_ff");
    send_frame(3, 9'h013, 16'b1_1_10011_0,      8, "w5_13");

    // Back-to-back words 01,02,03 with valid held high
    valid_s[0] = 1'b1;
    drive_data(0, 9'h001);
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d start", f), tx_s[0], 1'b0);
      chk($sformatf("b2b%0d ready", f), ready_s[0], 1'b0);
      chk($sformatf("b2b%0d busy", f), busy_s[0], 1'b1);
      if (f < 2) drive_data(0, 9'(f + 2));
      else valid_s[0] = 1'b0;
      repeat (5) @(negedge clk);
      chk($sformatf("b2b%0d d0", f), tx_s[0], b2b_bit0[f]);
      repeat (4) @(negedge clk);
      chk($sformatf("b2b%0d d1", f), tx_s[0], b2b_bit1[f]);
      repeat (35) @(negedge clk);
      chk($sformatf("b2b%0d done", f), done_s[0], 1'b1);
      chk($sformatf("b2b%0d ready idle", f), ready_s[0], 1'b1);
      chk($sformatf("b2b%0d tx idle", f), tx_s[0], 1'b1);
      chk($sformatf("b2b%0d busy idle", f), busy_s[0], 1'b0);
    end
    @(negedge clk);
    chk("b2b no fourth busy", busy_s[0], 1'b0);
    chk("b2b no fourth tx", tx_s[0], 1'b1);

    // Asynchronous reset in the middle of data bit 3 (A5 bit3 = 0)
    valid_s[0] = 1'b1;
    drive_data(0, 9'h0A5);
    @(negedge clk);
    valid_s[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort pre tx", tx_s[0], 1'b0);
    chk("abort pre busy", busy_s[0], 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("abort tx", tx_s[0], 1'b1);
    chk("abort busy", busy_s[0], 1'b0);
    chk("abort ready", ready_s[0], 1'b0);
    chk("abort done", done_s[0], 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort release ready", ready_s[0], 1'b1);
    chk("abort release tx", tx_s[0], 1'b1);
    send_frame(0, 9'h03C, 16'b1_0_0011_1100_0, 11, "post_abort_3c");

    // valid pulsed mid-frame must be ignored
    valid_s[0] = 1'b1;
    drive_data(0, 9'h081);
    @(negedge clk);
    valid_s[0] = 1'b0;
    for (int c = 1; c < 44; c++) begin
      @(negedge clk);
      chk($sformatf("busy pulse ready c%0d", c), ready_s[0], 1'b0);
      chk($sformatf("busy pulse busy c%0d", c), busy_s[0], 1'b1);
      if (c == 10) begin
        valid_s[0] = 1'b1;
        drive_data(0, 9'h0FF);
      end else begin
        valid_s[0] = 1'b0;
      end
    end
    @(negedge clk);
    chk("busy pulse done", done_s[0], 1'b1);
    chk("busy pulse ready idle", ready_s[0], 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("no second frame tx c%0d", c), tx_s[0], 1'b1);
      chk($sformatf("no second frame busy c%0d", c), busy_s[0], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
